// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: control codes, FSM states and helpers.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SLT   = 4'b0100,
        ALU_SUB   = 4'b0110,
        ALU_SLTU  = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_XOR   = 4'b1100,
        ALU_UNDEF = 4'b1111
    } alu_ctrl_e;

    typedef enum logic {
        IDLE,
        SHIFT
    } exec_state_e;

    function automatic logic is_shift(alu_ctrl_e code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations and undefined-code decode; purely combinational.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = alu_pkg::XLEN_DEFAULT
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_ctrl_e'(ctrl))
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            // shift codes only reach this path with a zero shift amount
            ALU_SLL, ALU_SRL, ALU_SRA: result = a;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: handshake FSM, iterative shifter and registered result/flags.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = alu_pkg::XLEN_DEFAULT,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam logic [5:0] STEP_LIM = 6'(SHIFT_STEP);

    exec_state_e     state, state_nxt;
    alu_ctrl_e       ctrl_in, sh_op;
    logic [4:0]      shamt, remaining, step;
    logic [XLEN-1:0] shreg, shifted, core_result;
    logic            core_illegal;
    logic            accept, shift_start, shift_last;

    assign ctrl_in     = alu_ctrl_e'(alu_ctrl);
    assign shamt       = op_b[4:0];
    assign accept      = in_valid && in_ready;
    assign shift_start = accept && is_shift(ctrl_in) && (shamt != '0);
    assign shift_last  = (state == SHIFT) && ({1'b0, remaining} <= STEP_LIM);

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .ctrl    (alu_ctrl),
        .a       (op_a),
        .b       (op_b),
        .result  (core_result),
        .illegal (core_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (shift_start) state_nxt = SHIFT;
            SHIFT:   if (shift_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == SHIFT);
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end

    always_comb begin
        step = ({1'b0, remaining} < STEP_LIM) ? remaining : STEP_LIM[4:0];
        case (sh_op)
            ALU_SLL: shifted = shreg << step;
            ALU_SRA: shifted = XLEN'($signed(shreg) >>> step);
            default: shifted = shreg >> step;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            remaining <= '0;
            sh_op     <= ALU_SLL;
        end else if (shift_start) begin
            shreg     <= op_a;
            remaining <= shamt;
            sh_op     <= ctrl_in;
        end else if (state == SHIFT) begin
            shreg     <= shifted;
            remaining <= remaining - step;
        end
    end

    // A shift accept loads nothing here, so a draining result simply retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !shift_start) begin
            out_valid <= 1'b1;
            result    <= core_result;
            zero      <= (core_result == '0);
            illegal   <= core_illegal;
        end else if (shift_last) begin
            out_valid <= 1'b1;
            result    <= shifted;
            zero      <= (shifted == '0);
            illegal   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage sitting directly downstream of ALUControl. It consumes the 4-bit ALU control code and two XLEN operands, and produces a registered result plus the zero and illegal flags.
- Logic ops, arithmetic and compares complete in one cycle.
- Shifts run iteratively over several cycles.
- Valid/ready handshakes on both sides allow the unit to stall fetch and to be stalled by writeback.

Parameters:
XLEN, 32, operand/result width.
SHIFT_STEP, 1, bits shifted per SHIFT cycle; must be a power of two, 1..16.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  operation request.
in_ready  out  1  unit accepts the request this cycle.
alu_ctrl  in  4  ALU control code.
op_a  in  XLEN  operand A.
op_b  in  XLEN  operand B; op_b[4:0] is the shift amount (shamt).
out_valid  out  1  result register holds a valid result.
out_ready  in  1  consumer takes the result this cycle.
result  out  XLEN  registered result.
zero  out  1  registered (result == 0); used for branch decisions.
illegal  out  1  registered flag: the code was undefined.
busy  out  1  high while state == SHIFT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid=0, result=0, zero=0, illegal=0, busy=0.
  - Any shift in progress is discarded; no output is produced for it.
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 XOR.
  - 0100 SLT: signed compare, result 0/1 zero-extended.
  - 0111 SLTU: unsigned compare, result 0/1 zero-extended.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - All other codes, including 1111: result=0, illegal=1, single-cycle.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Single-cycle ops, and shifts with shamt=0:
  - On the accept edge, the output register loads result, zero and illegal, and out_valid becomes 1.
  - Latency 1; throughput 1/cycle while out_ready=1.
- Shift with shamt>0:
  - On the accept edge: latch op_a into the shift register, remaining=shamt, latch the op; go to SHIFT.
  - The output register is guaranteed empty or draining in the accept cycle.
  - Each SHIFT edge shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
  - SRA fills with the sign bit; SRL and SLL fill with 0.
  - When remaining <= SHIFT_STEP at the edge: load the final value into the output register, set out_valid=1, illegal=0, and return to IDLE.
  - Latency = 1 + ceil(shamt/SHIFT_STEP) cycles.
  - in_ready=0 throughout SHIFT.
- Output register:
  - Holds result/zero/illegal stable while out_valid && !out_ready.
  - out_valid && out_ready with no new accept: out_valid falls next edge; result keeps its last value.
  - Drain and accept in the same cycle: the register is overwritten with the new result and out_valid stays 1.
- SHIFT never stalls on the output side: the output was freed at accept, so the final write is always accepted.
- in_valid is ignored when in_ready=0. Inputs are sampled only on the accept edge; they may change freely afterwards.

Decomposition:
- Package alu_pkg:
  - XLEN default.
  - Enum alu_ctrl_e with all codes above (including ALU_UNDEF=4'b1111).
  - State enum exec_state_e {IDLE, SHIFT}.
  - Helper function is_shift(alu_ctrl_e).
- One sub-module, alu_comb_core: purely combinational single-cycle ops and illegal-code decode.
- alu_exec_unit owns the FSM, the iterative shifter and the output register.

Test Plan:
- Reset mid-shift: SLL op_a=1 shamt=20, assert rst_n=0 at cycle 3 -> out_valid=0, busy=0, result=0 immediately; no result emitted after release.
- Back-to-back with out_ready=1:
  - ADD 5+7 -> result=12.
  - SUB 7-7 -> result=0, zero=1.
  - SLT -1 vs 1 -> 1.
  - SLTU 0xFFFFFFFF vs 1 -> 0.
  - One result per cycle; in_ready stays 1.
- SRA op_a=0x80000000 shamt=4, SHIFT_STEP=1 -> busy for 4 cycles, in_ready=0; out_valid in cycle 5 after accept, result=0xF8000000.
- Backpressure: out_ready=0 after XOR 0xF0^0xFF -> result=0x0F held, in_ready=0; raising out_ready with in_valid=1 (OR) overwrites in the same edge, out_valid stays 1.
- Undefined code 1111 and 0011 -> result=0, illegal=1, zero=1, latency 1; next legal op clears illegal.
- SHIFT_STEP=4, SRL 0xFFFFFFFF shamt=31 -> latency 1+8=9 cycles, result=0x00000001; shamt=0 -> latency 1, result=op_a.
